// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared req/ready memory port.
// Outputs are combinational from state; memory waits stretch FETCH/MEM until ready or timeout -> TRAP.
module multicycle_control_unit #(
   parameter int OPCODE_W    = 6,
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int HALT_OP     = 63
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_write,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                reg_dst,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal,
   output logic                bus_err,
   output logic [2:0]          state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_IMM  = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(HALT_OP);

   // Counter only ever needs to hold MEM_TIMEOUT-1 before the timeout fires.
   localparam int               CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t              state;
   state_t              state_nxt;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    wait_cnt;
   logic                mem_wait;
   logic                timeout;
   logic                dec_legal;
   logic                dec_halt;

   assign mem_wait  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
   assign timeout   = TIMEOUT_EN && mem_wait && (wait_cnt == WAIT_LAST);
   assign dec_halt  = (opcode == OP_HALT);
   assign dec_legal = (opcode == OP_R)  || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ)  || (opcode == OP_IMM);
   assign state_o   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op_q     <= '0;
         wait_cnt <= '0;
         illegal  <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            op_q <= opcode;
            if (!dec_legal && !dec_halt) begin
               illegal <= 1'b1;
            end
         end
         if (timeout) begin
            bus_err <= 1'b1;
         end
         // Any cycle that is not a stalled request restarts the count, so entry to FETCH/MEM starts at 0.
         if (mem_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ready)    state_nxt = S_DECODE;
            else if (timeout) state_nxt = S_TRAP;
         end
         S_DECODE: begin
            if (dec_legal)     state_nxt = S_EXEC;
            else if (dec_halt) state_nxt = S_HALTED;
            else               state_nxt = S_TRAP;
         end
         S_EXEC: begin
            if ((op_q == OP_LW) || (op_q == OP_SW)) state_nxt = S_MEM;
            else if (op_q == OP_BEQ)                state_nxt = S_FETCH;
            else                                    state_nxt = S_WB;
         end
         S_MEM: begin
            if (mem_ready)    state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
            else if (timeout) state_nxt = S_TRAP;
         end
         S_WB:     state_nxt = S_FETCH;
         S_HALTED: state_nxt = S_HALTED;
         S_TRAP:   state_nxt = S_TRAP;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_op     = '0;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_EXEC: begin
            alu_src = !((op_q == OP_R) || (op_q == OP_BEQ));
            if (op_q == OP_R)         alu_op = ALU_OP_W'(0);
            else if (op_q == OP_BEQ)  alu_op = ALU_OP_W'(1);
            else if (op_q == OP_ADDI) alu_op = ALU_OP_W'(2);
            else                      alu_op = ALU_OP_W'(3);
            if (op_q == OP_BEQ) begin
               pc_write = zero;
               pc_src   = 1'b1;
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            alu_src   = 1'b1;
            alu_op    = ALU_OP_W'(3);
            mem_write = (op_q == OP_SW);
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OP_R);
            mem_to_reg = (op_q == OP_LW);
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle directed bench for multicycle_control_unit: instruction-stream table plus wait/timeout/trap sequences.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, ir_write, pc_write, pc_src, reg_dst;
   logic       alu_src, mem_to_reg, reg_write, illegal, bus_err;
   logic [2:0] alu_op;
   logic [2:0] state_o;
   logic [13:0] act_ctl;

   multicycle_control_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_dst    (reg_dst),
      .alu_src    (alu_src),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .bus_err    (bus_err),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   assign act_ctl = {mem_req, mem_write, ir_write, pc_write, pc_src, reg_dst, alu_src,
                     mem_to_reg, reg_write, alu_op, illegal, bus_err};

   localparam logic [13:0] REQ = 14'h2000, MW  = 14'h1000, IRW = 14'h0800, PCW = 14'h0400;
   localparam logic [13:0] PCS = 14'h0200, RD  = 14'h0100, AS  = 14'h0080, M2R = 14'h0040;
   localparam logic [13:0] RW  = 14'h0020, A1  = 14'h0004, A2  = 14'h0008, A3  = 14'h000C;
   localparam logic [13:0] ILL = 14'h0002, BE  = 14'h0001, NONE = 14'h0000;
   localparam logic [13:0] FET = REQ | IRW | PCW;

   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3;
   localparam logic [2:0] MEM  = 3'd4, WB    = 3'd5, HALTED = 3'd6, TRAP = 3'd7;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic        z;
      logic        rdy;
      logic [2:0]  st;
      logic [13:0] ctl;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic vec_t mk(input string n, input logic [5:0] op, input logic z, input logic rdy,
                               input logic [2:0] st, input logic [13:0] ctl);
      vec_t v;
      v.name = n; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // One clock cycle: drive inputs just after the falling edge, check, then advance to the next falling edge.
   task automatic cyc(input string name, input logic [5:0] op, input logic z, input logic rdy,
                      input logic [2:0] st, input logic [13:0] ctl);
      opcode = op; zero = z; mem_ready = rdy;
      #1;
      chk({name, "/state"}, 16'(state_o), 16'(st));
      chk({name, "/ctl"}, 16'(act_ctl), 16'(ctl));
      @(negedge clk);
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0; opcode = 6'd2; zero = 1'b1; mem_ready = 1'b1;
      #1;
      chk({name, "/async_state"}, 16'(state_o), 16'(IDLE));
      chk({name, "/async_ctl"}, 16'(act_ctl), 16'(NONE));
      @(negedge clk);
      chk({name, "/held_state"}, 16'(state_o), 16'(IDLE));
      chk({name, "/held_ctl"}, 16'(act_ctl), 16'(NONE));
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

      // Zero-wait stream; opcode/zero/mem_ready carry junk outside the states that sample them.
      tbl.push_back(mk("idle",     6'd2,  1, 1, IDLE,   NONE));
      tbl.push_back(mk("r_fetch",  6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("r_dec",    6'd0,  0, 0, DECODE, NONE));
      tbl.push_back(mk("r_exec",   6'd2,  1, 1, EXEC,   NONE));
      tbl.push_back(mk("r_wb",     6'd9,  0, 1, WB,     RW | RD));
      tbl.push_back(mk("a_fetch",  6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("a_dec",    6'd1,  1, 0, DECODE, NONE));
      tbl.push_back(mk("a_exec",   6'd3,  1, 0, EXEC,   AS | A2));
      tbl.push_back(mk("a_wb",     6'd0,  0, 0, WB,     RW));
      tbl.push_back(mk("s_fetch",  6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("s_dec",    6'd5,  0, 0, DECODE, NONE));
      tbl.push_back(mk("s_exec",   6'd63, 0, 1, EXEC,   AS | A3));
      tbl.push_back(mk("s_mem",    6'd2,  0, 1, MEM,    REQ | MW | AS | A3));
      tbl.push_back(mk("b1_fetch", 6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("b1_dec",   6'd6,  0, 0, DECODE, NONE));
      tbl.push_back(mk("b1_exec",  6'd2,  1, 0, EXEC,   PCW | PCS | A1));
      tbl.push_back(mk("b0_fetch", 6'd2,  1, 1, FETCH,  FET));
      tbl.push_back(mk("b0_dec",   6'd6,  1, 0, DECODE, NONE));
      tbl.push_back(mk("b0_exec",  6'd6,  0, 1, EXEC,   PCS | A1));
      tbl.push_back(mk("l_fetch",  6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("l_dec",    6'd4,  0, 0, DECODE, NONE));
      tbl.push_back(mk("l_exec",   6'd0,  1, 0, EXEC,   AS | A3));
      tbl.push_back(mk("l_mem",    6'd0,  0, 1, MEM,    REQ | AS | A3));
      tbl.push_back(mk("l_wb",     6'd1,  1, 1, WB,     RW | M2R));
      tbl.push_back(mk("i_fwait",  6'd2,  0, 0, FETCH,  REQ));
      tbl.push_back(mk("i_fetch",  6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("i_dec",    6'd7,  0, 0, DECODE, NONE));
      tbl.push_back(mk("i_exec",   6'd0,  0, 0, EXEC,   AS | A3));
      tbl.push_back(mk("i_wb",     6'd5,  1, 0, WB,     RW));
      tbl.push_back(mk("e_fetch",  6'd2,  0, 1, FETCH,  FET));
      tbl.push_back(mk("e_dec",    6'd0,  0, 0, DECODE, NONE));

      @(negedge clk);
      do_reset("por");
      foreach (tbl[i]) cyc(tbl[i].name, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].st, tbl[i].ctl);

      // LW with mem_ready delayed three cycles in MEM.
      do_reset("rst_lw");
      cyc("lw_idle",  6'd0, 0, 0, IDLE,   NONE);
      cyc("lw_fetch", 6'd0, 0, 1, FETCH,  FET);
      cyc("lw_dec",   6'd4, 0, 0, DECODE, NONE);
      cyc("lw_exec",  6'd0, 0, 0, EXEC,   AS | A3);
      for (int k = 0; k < 3; k++) cyc("lw_memwait", 6'd0, 0, 0, MEM, REQ | AS | A3);
      cyc("lw_memrdy", 6'd0, 0, 1, MEM,   REQ | AS | A3);
      cyc("lw_wb",     6'd0, 0, 1, WB,    RW | M2R);
      cyc("lw_next",   6'd0, 0, 0, FETCH, REQ);

      // FETCH stalled for the full timeout window.
      do_reset("rst_to");
      cyc("to_idle", 6'd0, 0, 0, IDLE, NONE);
      for (int k = 0; k < 15; k++) cyc("to_wait", 6'd0, 0, 0, FETCH, REQ);
      for (int k = 0; k < 3; k++)  cyc("to_trap", 6'd1, 1, 1, TRAP, BE);

      // Ready on the last permitted cycle completes normally; then a store times out in MEM.
      do_reset("rst_edge");
      cyc("edge_idle", 6'd0, 0, 0, IDLE, NONE);
      for (int k = 0; k < 14; k++) cyc("edge_wait", 6'd0, 0, 0, FETCH, REQ);
      cyc("edge_fetch", 6'd0, 0, 1, FETCH,  FET);
      cyc("edge_dec",   6'd0, 0, 0, DECODE, NONE);
      cyc("edge_exec",  6'd0, 0, 0, EXEC,   NONE);
      cyc("edge_wb",    6'd0, 0, 0, WB,     RW | RD);
      cyc("mt_fetch",   6'd0, 0, 1, FETCH,  FET);
      cyc("mt_dec",     6'd5, 0, 0, DECODE, NONE);
      cyc("mt_exec",    6'd0, 0, 0, EXEC,   AS | A3);
      for (int k = 0; k < 15; k++) cyc("mt_wait", 6'd0, 0, 0, MEM, REQ | MW | AS | A3);
      cyc("mt_trap", 6'd0, 0, 1, TRAP, BE);

      // Illegal opcode traps and stays trapped.
      do_reset("rst_ill");
      cyc("ill_idle",  6'd0, 0, 0, IDLE,   NONE);
      cyc("ill_fetch", 6'd0, 0, 1, FETCH,  FET);
      cyc("ill_dec",   6'd2, 0, 0, DECODE, NONE);
      for (int k = 0; k < 3; k++) cyc("ill_trap", 6'd63, 1, 1, TRAP, ILL);

      // HALT stops without raising illegal.
      do_reset("rst_halt");
      cyc("halt_idle",  6'd0,  0, 0, IDLE,   NONE);
      cyc("halt_fetch", 6'd0,  0, 1, FETCH,  FET);
      cyc("halt_dec",   6'd63, 0, 0, DECODE, NONE);
      for (int k = 0; k < 3; k++) cyc("halt_hold", 6'd2, 1, 1, HALTED, NONE);

      // Reset while a store is about to hit memory.
      do_reset("rst_pre");
      cyc("mid_idle",  6'd0, 0, 0, IDLE,   NONE);
      cyc("mid_fetch", 6'd0, 0, 1, FETCH,  FET);
      cyc("mid_dec",   6'd5, 0, 0, DECODE, NONE);
      cyc("mid_exec",  6'd0, 0, 0, EXEC,   AS | A3);
      do_reset("rst_mid");
      cyc("mid_after", 6'd0, 0, 0, IDLE, NONE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
